tm_fir_mac_seq: RTL and testbench

- Control and datapath core of the time-multiplexed FIR filter.
- Sits on both sides of the one-hot coefficient mux:
  - drives its one-hot tap select;
  - consumes the combinational coefficient it returns.
- Holds the sample delay line and runs one multiply-accumulate per tap, N cycles per output sample.
- Presents the filtered result on a valid/ready handshake.

---
 rtl/tm_fir_pkg.sv | 41 ++++
 rtl/tm_fir_delay_line.sv | 28 ++
 rtl/tm_fir_mac_seq.sv | 117 +++++++++++
 tb/tb_tm_fir_mac_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_fir_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed FIR core.
package tm_fir_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fir_state_t;

  localparam int DEF_N   = 3;
  localparam int DEF_WII = 2;
  localparam int DEF_WFI = 6;
  localparam int DEF_WIO = 2;
  localparam int DEF_WFO = 6;
  localparam int DEF_WIY = 2;
  localparam int DEF_WFY = 6;

  function automatic int prod_width(input int wii, input int wfi, input int wio, input int wfo);
    return wii + wfi + wio + wfo;
  endfunction

  function automatic int guard_width(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int acc_width(input int pw, input int n);
    return pw + guard_width(n);
  endfunction

  // Floor-truncate 'shift' fraction bits, then clamp to a wy-bit signed range when sat_en;
  // otherwise the caller keeps the low wy bits and the integer part wraps.
  function automatic logic signed [63:0] fit_out(input logic signed [63:0] acc, input int shift,
                                                 input int wy, input logic sat_en);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (wy - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wy - 1));
    if (sat_en && (s > hi)) return hi;
    if (sat_en && (s < lo)) return lo;
    return s;
  endfunction

endpackage

// File: rtl/tm_fir_delay_line.sv
// N-deep sample shift register (x[0] newest) with sync clear; read port indexed by the tap counter.
module tm_fir_delay_line #(
  parameter int N  = 3,
  parameter int W  = 8,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          shift_en,
  input  logic [W-1:0]  din,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  dout
);

  logic [W-1:0] x [N];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) x[i] <= '0;
    end else if (shift_en) begin
      x[0] <= din;
      for (int i = 1; i < N; i++) x[i] <= x[i-1];
    end
  end

  assign dout = x[k];

endmodule

// File: rtl/tm_fir_mac_seq.sv
// FIR MAC sequencer: one tap per cycle, result valid N+1 cycles after accept and held until out_ready.
// Define TM_FIR_SAT_EN for a saturating output; otherwise the integer part wraps.
module tm_fir_mac_seq
  import tm_fir_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int WII = DEF_WII,
  parameter int WFI = DEF_WFI,
  parameter int WIO = DEF_WIO,
  parameter int WFO = DEF_WFO,
  parameter int WIY = DEF_WIY,
  parameter int WFY = DEF_WFY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WII+WFI-1:0]   x_in,
  output logic [N-1:0]         tap_sel,
  input  logic [WIO+WFO-1:0]   coeff_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIY+WFY-1:0]   y_out
);

  localparam int WX = WII + WFI;
  localparam int WC = WIO + WFO;
  localparam int WY = WIY + WFY;
  localparam int PW = prod_width(WII, WFI, WIO, WFO);
  localparam int AW = acc_width(PW, N);
  localparam int SH = WFI + WFO - WFY;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
`ifdef TM_FIR_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  fir_state_t           state;
  logic [KW-1:0]        k;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic [WX-1:0]        xk;
  logic signed [PW-1:0] xk_ext;
  logic signed [PW-1:0] c_ext;
  logic signed [PW-1:0] prod;
  logic [WY-1:0]        y_fit;
  logic                 shift_en;

  // in_ready is only ever high in IDLE, so it doubles as the accept qualifier.
  assign shift_en = in_valid && in_ready;

  tm_fir_delay_line #(.N(N), .W(WX), .KW(KW)) u_dly (
    .clk      (clk),
    .clr      (!rst_n),
    .shift_en (shift_en),
    .din      (x_in),
    .k        (k),
    .dout     (xk)
  );

  assign xk_ext  = PW'($signed(xk));
  assign c_ext   = PW'($signed(coeff_in));
  assign prod    = xk_ext * c_ext;
  assign acc_nxt = acc + AW'(prod);
  assign y_fit   = WY'(fit_out(64'(acc_nxt), SH, WY, SAT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      tap_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (shift_en) begin
            state    <= RUN;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            tap_sel  <= N'(1);
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (k == KW'(N - 1)) begin
            state     <= DONE;
            k         <= '0;
            tap_sel   <= '0;
            out_valid <= 1'b1;
            y_out     <= y_fit;
          end else begin
            k       <= k + 1'b1;
            tap_sel <= tap_sel << 1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          tap_sel  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm_fir_mac_seq.sv
// Scoreboard bench for tm_fir_mac_seq: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_tm_fir_mac_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] x_in = 8'h00;
  logic [7:0] coeff_in;
  logic [7:0] y_out;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] tap_sel;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ov_exp[6];
  bit         big_coeff = 1'b0;
  bit         b2b = 1'b0;

  tm_fir_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .tap_sel   (tap_sel),
    .coeff_in  (coeff_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
  );

  initial forever #5 clk = ~clk;

  // Coefficient ROM model: h = {1.0, 0.5, -0.5}, or all 0x7F for the overflow vectors.
  always_comb begin
    coeff_in = 8'h00;
    case (tap_sel)
      3'b001:  coeff_in = big_coeff ? 8'h7F : 8'h40;
      3'b010:  coeff_in = big_coeff ? 8'h7F : 8'h20;
      3'b100:  coeff_in = big_coeff ? 8'h7F : 8'hE0;
      default: coeff_in = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: tap_sel sequence, acceptance-to-valid latency, back-to-back spacing, output scoreboard.
  int phase = 0;
  int cyc = 0;
  int last_acc = 0;
  bit have_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!b2b) have_prev = 1'b0;
    if (!rst_n) begin
      phase = 0;
      exp_q.delete();
    end else begin
      if (phase >= 1 && phase <= 3) begin
        chk("tap_sel_run", 32'(tap_sel), 32'(1) << (phase - 1));
        chk("in_ready_run", 32'(in_ready), 32'd0);
      end else begin
        chk("tap_sel_off", 32'(tap_sel), 32'd0);
      end
      if (phase == 4) begin
        chk("latency", 32'(out_valid), 32'd1);
        phase = 0;
      end else if (phase >= 1) begin
        phase++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else chk("y_out", 32'(y_out), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        if (have_prev) chk("b2b_interval", 32'(cyc - last_acc), 32'd5);
        have_prev = b2b;
        last_acc  = cyc;
        phase     = 1;
      end
    end
  end

  task automatic issue(input logic [7:0] x, input logic [7:0] e, input bit push);
    if (push) exp_q.push_back(e);
    x_in     = x;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        timeout("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] e);
    issue(x, e, 1'b1);
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) break;
      n++;
      if (n > 100) begin
        timeout("drain");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef TM_FIR_SAT_EN
    ov_exp = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80};
`else
    ov_exp = '{8'hBC, 8'h79, 8'hF4, 8'hFA, 8'h00, 8'h06};
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_tap_sel", 32'(tap_sel), 32'd0);
    chk("rst_y_out", 32'(y_out), 32'd0);
    @(posedge clk);
    #1;

    // Impulse response
    send(8'h40, 8'h40);
    send(8'h00, 8'h20);
    send(8'h00, 8'hE0);

    // Backpressure: second sample held on in_valid while the first result sits in DONE
    wait_idle();
    send(8'h20, 8'h20);
    out_ready = 1'b0;
    issue(8'hC0, 8'hD0, 1'b1);
    begin
      int n = 0;
      while (1) begin
        @(negedge clk);
        if (out_valid) break;
        n++;
        if (n > 20) begin
          timeout("out_valid");
          break;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_y_out", 32'(y_out), 32'h20);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();

    // Overflow vectors with all coefficients 0x7F
    wait_idle();
    big_coeff = 1'b1;
    for (int i = 0; i < 3; i++) send(8'h7F, ov_exp[i]);
    for (int i = 0; i < 3; i++) send(8'h80, ov_exp[3+i]);
    wait_idle();
    big_coeff = 1'b0;

    // Reset while the second tap is being accumulated
    issue(8'h40, 8'h00, 1'b0);
    wait_accept();
    begin
      int n = 0;
      while (1) begin
        @(negedge clk);
        if (tap_sel == 3'b010) break;
        n++;
        if (n > 10) begin
          timeout("tap_k1");
          break;
        end
      end
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tap_sel", 32'(tap_sel), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h40, 8'h40);

    // Back-to-back with in_valid held and out_ready high
    wait_idle();
    b2b = 1'b1;
    send(8'h20, 8'h40);
    send(8'h40, 8'h30);
    send(8'hC0, 8'hD0);
    send(8'h00, 8'hC0);
    wait_idle();
    b2b = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
